// File: rtl/apb_pwm.sv
// apb_pwm: APB-style responder driving one PWM output from a free-running counter.
// Registers (offsets from baseAddr): 0 CTRL {OVF,INV,EN}, 1 PERIOD, 2 DUTY, 3 CNT (read-only).
// PERIOD/DUTY are double-buffered: bus writes land in shadows, and the active copies
// reload while EN=0 or on the counter wrap cycle.
// Optional build macro: APB_PWM_WAIT_STATE_EN inserts one wait state per in-window access.
module apb_pwm #(
  parameter int          dataWidth = 8,
  parameter int          addrWidth = 32,
  parameter int unsigned baseAddr  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sel,
  input  logic                 enable,
  input  logic                 write,
  input  logic [addrWidth-1:0] addr,
  input  logic [dataWidth-1:0] wdata,
  output logic [dataWidth-1:0] rdata,
  output logic                 ready,
  output logic                 slverr,
  output logic                 pwm_out
);

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_PERIOD = 2'd1,
    REG_DUTY   = 2'd2,
    REG_CNT    = 2'd3
  } reg_e;

  // Register state
  logic                 en_q, inv_q, ovf_q;
  logic [dataWidth-1:0] period_sh_q, period_act_q, duty_sh_q, duty_act_q, cnt_q;
  logic                 pwm_q;

  // Next-state values
  logic                 en_d, inv_d, ovf_d;
  logic [dataWidth-1:0] period_sh_d, period_act_d, duty_sh_d, duty_act_d, cnt_d;
  logic                 pwm_d;

  // Address decode: offset relative to the window base, unsigned compare covers both ends.
  logic [addrWidth-1:0] offset;
  logic                 in_window;
  logic                 access;
  reg_e                 reg_sel;

  assign offset    = addr - addrWidth'(baseAddr);
  assign in_window = (offset < addrWidth'(4));
  assign reg_sel   = reg_e'(offset[1:0]);
  // Reset gates the handshake so an access in flight is dropped immediately.
  assign access    = reset & sel & enable & in_window;

`ifdef APB_PWM_WAIT_STATE_EN
  logic wait_q, wait_d;

  // First access cycle arms the flag; it drops once the transfer completes or sel/enable fall.
  assign wait_d = access & ~wait_q;
  assign ready  = access & wait_q;

  // Wait-state flag register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wait_q <= 1'b0;
    else        wait_q <= wait_d;
  end
`else
  assign ready = access;
`endif

  logic wr_en;
  logic wrap;

  assign wr_en  = ready & write;
  assign slverr = ready & write & (reg_sel == REG_CNT);
  assign wrap   = en_q & (cnt_q == period_act_q);

  // Read mux: returns shadow PERIOD/DUTY, live counter; zero outside a completing read.
  always_comb begin
    rdata = '0;
    if (ready && !write) begin
      unique case (reg_sel)
        REG_CTRL:   rdata[2:0] = {ovf_q, inv_q, en_q};
        REG_PERIOD: rdata      = period_sh_q;
        REG_DUTY:   rdata      = duty_sh_q;
        REG_CNT:    rdata      = cnt_q;
      endcase
    end
  end

  // Next-state logic for bus registers, double buffers, counter and PWM output.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    en_d         = en_q;
    inv_d        = inv_q;
    ovf_d        = ovf_q;
    period_sh_d  = period_sh_q;
    duty_sh_d    = duty_sh_q;
    period_act_d = period_act_q;
    duty_act_d   = duty_act_q;

    if (wr_en) begin
      unique case (reg_sel)
        REG_CTRL: begin
          en_d  = wdata[0];
          inv_d = wdata[1];
          if (wdata[2]) ovf_d = 1'b0;
        end
        REG_PERIOD: period_sh_d = wdata;
        REG_DUTY:   duty_sh_d   = wdata;
        REG_CNT:    ;  // read-only, error flagged via slverr
      endcase
    end

    // Hardware set is applied after the W1C so a coincident wrap wins.
    if (wrap) ovf_d = 1'b1;

    if (!en_q || wrap) begin
      period_act_d = period_sh_q;
      duty_act_d   = duty_sh_q;
    end

    cnt_d = (en_q && !wrap) ? cnt_q + dataWidth'(1) : '0;
    pwm_d = (en_q & (cnt_q < duty_act_q)) ^ inv_q;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (!reset) begin
      en_q         <= 1'b0;
      inv_q        <= 1'b0;
      ovf_q        <= 1'b0;
      period_sh_q  <= '1;
      period_act_q <= '1;
      duty_sh_q    <= '0;
      duty_act_q   <= '0;
      cnt_q        <= '0;
      pwm_q        <= 1'b0;
    end else begin
      en_q         <= en_d;
      inv_q        <= inv_d;
      ovf_q        <= ovf_d;
      period_sh_q  <= period_sh_d;
      period_act_q <= period_act_d;
      duty_sh_q    <= duty_sh_d;
      duty_act_q   <= duty_act_d;
      cnt_q        <= cnt_d;
      pwm_q        <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule

// File: doc/apb_pwm.md
# apb_pwm

APB-style responder peripheral producing a single PWM output from a free-running 8-bit counter. It sits on the same peripheral bus as the timer block, uses the same sel/enable/write/addr/wdata/rdata/ready/slverr handshake, and is driven by the same bus-initiator tasks. Software programs the period and duty registers, enables the generator, and polls the counter and an overflow flag.

## Interface
- `dataWidth`, default 8: register and data-bus width.
- `addrWidth`, default 32: address-bus width.
- `baseAddr`, default 4: address of the first register; the block decodes `baseAddr`..`baseAddr+3`.
- `clk` input, 1 bit: the single clock; everything is on rising edges.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `sel` input, 1 bit: peripheral select.
- `enable` input, 1 bit: access phase.
- `write` input, 1 bit: 1 = write, 0 = read.
- `addr` input, `addrWidth` bits: byte address.
- `wdata` input, `dataWidth` bits: write data.
- `rdata` output, `dataWidth` bits: read data; 0 whenever `ready` is low.
- `ready` output, 1 bit: transfer completes on the rising edge where `sel & enable & ready`.
- `slverr` output, 1 bit: error; valid only while `ready` is high, otherwise 0.
- `pwm_out` output, 1 bit: PWM waveform.

## Operation
- Register map:
  - `baseAddr+0` CTRL:
    - bit0 EN (R/W).
    - bit1 INV (R/W).
    - bit2 OVF (sticky; write 1 to clear, write 0 has no effect).
    - bits[7:3] read 0.
  - `baseAddr+1` PERIOD (R/W, reset 0xFF).
  - `baseAddr+2` DUTY (R/W, reset 0x00).
  - `baseAddr+3` CNT (read-only; a write returns `slverr=1` and changes nothing).
- Address decode:
  - An address outside the window gets no response: `ready`, `slverr` and `rdata` stay 0, and no state changes.
  - With `sel=0`, `enable` is ignored.
- PERIOD and DUTY are double-buffered. Bus writes go to shadow registers. The active copies load from the shadows when EN=0 (every cycle) or on the cycle the counter wraps. Reads return the shadow value.
- Counter behaviour:
  - While EN=1: if `cnt == period_act`, the next value is 0 and OVF is set; otherwise `cnt` increments by 1.
  - While EN=0: `cnt` is forced to 0.
- `pwm_raw = EN & (cnt < duty_act)` and `pwm_out = pwm_raw ^ INV`. `pwm_out` is registered, so it lags `cnt` by one cycle.
- Boundary cases:
  - `duty_act > period_act`: output constantly active.
  - `duty_act == 0`: constantly inactive.
  - `period_act == 0`: `cnt` stays 0, OVF sets every cycle, and the output is active iff `duty_act != 0`.
- Simultaneous events:
  - Hardware OVF set and a W1C clear in the same cycle: the set wins.
  - A CTRL write with EN=0 clears `cnt` on the next edge.

## Timing
- Reset (asynchronous, while `reset=0`):
  - `rdata`=0, `ready`=0, `slverr`=0, `pwm_out`=INV reset value (0).
  - CTRL=0, `cnt`=0, PERIOD shadow/active=0xFF, DUTY shadow/active=0.
- Reset asserted mid-transfer aborts it; no write is committed.
- Zero-wait mode (default):
  - `ready = sel & enable & in_window`, combinational.
  - Reads and writes complete in the first access cycle.
- Write commit happens on the completing edge. The new register value is visible to the counter logic on the following cycle.
- `rdata` is combinational from the registers during the access phase.
- `cnt` read during a transfer returns its value in the completing cycle.

## Configuration
- `APB_PWM_WAIT_STATE_EN`: when defined, every in-window access inserts exactly one wait state.
  - `ready` is low in the first access cycle and high in the second, driven from a registered flag.
  - The flag clears when `enable` drops or `sel` drops.
  - Write commit and `rdata` sampling move to the second access cycle.
- When undefined, the block uses zero-wait behaviour as above.

## Test plan
- Reset, then read all four registers → CTRL=0x00, PERIOD=0xFF, DUTY=0x00, CNT=0x00, `slverr=0`.
- Write 0x55 to `baseAddr+7`, then read it → `ready` never rises, `rdata=0`, no register changes. Repeat the access with `sel=0` → no response.
- Write CNT=0x12 → `slverr=1` on the completing cycle; CNT still reads 0.
- Program PERIOD=9, DUTY=3, CTRL=0x01 → `pwm_out` is high 3 cycles and low 7, repeating every 10 cycles. OVF reads 1 after the first wrap. Writing CTRL=0x05 clears OVF and keeps EN.
- While running with PERIOD=9, write DUTY=6 mid-period → duty stays 3 until the next wrap, then becomes 6. Write CTRL=0x03 → waveform inverted.
- With `APB_PWM_WAIT_STATE_EN` defined, repeat the register read → `ready` rises exactly one cycle after `enable`. Assert `reset` low mid-access → outputs return to reset values immediately.
